// File: rtl/l2_writeback_buffer_if.sv
// l2_writeback_buffer_if: L2-side and adaptor-side line buses of the writeback buffer.
// slave is the buffer's view; master is the surrounding L2/adaptor environment.
interface l2_writeback_buffer_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
);
    logic [ADDR_W-1:0]      up_address;
    logic                   up_read;
    logic                   up_write;
    logic [LINE_W-1:0]      up_wdata;
    logic [LINE_W-1:0]      up_rdata;
    logic                   up_resp;
    logic [ADDR_W-1:0]      dn_address;
    logic                   dn_read;
    logic                   dn_write;
    logic [LINE_W-1:0]      dn_wdata;
    logic [LINE_W-1:0]      dn_rdata;
    logic                   dn_resp;
    logic [$clog2(DEPTH):0] count;

    modport slave (
        input  up_address, up_read, up_write, up_wdata, dn_rdata, dn_resp,
        output up_rdata, up_resp, dn_address, dn_read, dn_write, dn_wdata, count
    );
    modport master (
        output up_address, up_read, up_write, up_wdata, dn_rdata, dn_resp,
        input  up_rdata, up_resp, dn_address, dn_read, dn_write, dn_wdata, count
    );
endinterface

// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: absorbs L2 dirty evictions in a small FIFO and drains them to the adaptor,
// servicing L2 read misses ahead of drains and answering reads that hit buffered lines.
module l2_writeback_buffer #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2,
    parameter int OFFSET = 5
) (
    input logic                  clk,
    input logic                  reset_n,
    l2_writeback_buffer_if.slave wb_if
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFSET) - ADDR_W'(1));

    typedef enum logic [1:0] {DN_IDLE, DN_READ, DN_WRITE} dn_state_e;

    dn_state_e         state_q, state_d;
    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              up_resp_q, up_resp_d;
    logic [LINE_W-1:0] up_rdata_q, up_rdata_d;

    logic [ADDR_W-1:0] up_addr;
    logic              rd_req, wr_req, rd_hit, wr_hit, rd_miss, full, push, coal, pop, rd_done;
    logic [PW-1:0]     rd_idx, wr_idx;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign up_addr = wb_if.up_address & LINE_MASK;
    // The cycle carrying up_resp still sees the held request; ignore it to avoid double acceptance.
    assign rd_req  = wb_if.up_read & ~up_resp_q;
    assign wr_req  = wb_if.up_write & ~up_resp_q;

    // Walk entries oldest to newest so the last match is the newest copy of a line.
    always_comb begin
        logic [PW-1:0] k;
        k      = '0;
        rd_hit = 1'b0;
        wr_hit = 1'b0;
        rd_idx = '0;
        wr_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            k = head_q + PW'(i);
            if (valid_q[k] && addr_q[k] == up_addr) begin
                rd_hit = 1'b1;
                rd_idx = k;
                if (!(k == head_q && state_q == DN_WRITE)) begin
                    wr_hit = 1'b1;
                    wr_idx = k;
                end
            end
        end
    end

    assign full    = count_q == CW'(DEPTH);
    assign rd_miss = rd_req & ~rd_hit;
    assign coal    = wr_req & wr_hit;
    assign push    = wr_req & ~wr_hit & ~full;
    assign pop     = state_q == DN_WRITE && wb_if.dn_resp;
    assign rd_done = state_q == DN_READ && wb_if.dn_resp;

    always_comb begin
        head_d     = pop ? inc(head_q) : head_q;
        tail_d     = push ? inc(tail_q) : tail_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        up_resp_d  = push | coal | (rd_req & rd_hit) | rd_done;
        up_rdata_d = rd_done ? wb_if.dn_rdata : (rd_req & rd_hit) ? data_q[rd_idx] : up_rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q == DN_IDLE ? (rd_miss ? DN_READ : count_q != '0 ? DN_WRITE : DN_IDLE)
                : wb_if.dn_resp ? DN_IDLE : state_q;
    end

    always_comb begin
        wb_if.dn_read    = state_q == DN_READ;
        wb_if.dn_write   = state_q == DN_WRITE;
        wb_if.dn_address = state_q == DN_READ ? up_addr : state_q == DN_WRITE ? addr_q[head_q] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            up_resp_q  <= 1'b0;
            up_rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= up_addr;
                data_q[tail_q]  <= wb_if.up_wdata;
            end
            if (coal) data_q[wr_idx] <= wb_if.up_wdata;
            if (pop) valid_q[head_q] <= 1'b0;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            up_resp_q  <= up_resp_d;
            up_rdata_q <= up_rdata_d;
        end
    end

    assign wb_if.dn_wdata = valid_q[head_q] ? data_q[head_q] : '0;
    assign wb_if.up_resp  = up_resp_q;
    assign wb_if.up_rdata = up_rdata_q;
    assign wb_if.count    = count_q;
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb_l2_writeback_buffer: scenario tasks driving the L2 side, with an adaptor model that checks
// every downstream transaction against a queue of expected accesses.
module tb_l2_writeback_buffer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    bit   stall = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_dn_done = 0;

    typedef struct { bit wr; logic [31:0] a; logic [255:0] d; } dn_t;
    dn_t            exp_dn[$];
    logic [255:0]   up_q[$];
    logic [255:0]   mem [logic [31:0]];

    l2_writeback_buffer_if #(.LINE_W(256), .ADDR_W(32), .DEPTH(2)) bus ();

    l2_writeback_buffer #(.LINE_W(256), .ADDR_W(32), .DEPTH(2), .OFFSET(5)) dut (
        .clk(clk), .reset_n(reset_n), .wb_if(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] dp(input int n);
        return {8{32'hD00D_0000 + 32'(n)}};
    endfunction

    function automatic logic [255:0] mem_init(input logic [31:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    task automatic exp_w(input logic [31:0] a, input logic [255:0] d);
        exp_dn.push_back('{1'b1, a, d});
    endtask

    task automatic exp_r(input logic [31:0] a);
        exp_dn.push_back('{1'b0, a, '0});
    endtask

    // Adaptor model: answers after a short latency unless stalled, checking each access in order.
    initial begin
        int  wcnt;
        dn_t e;
        wcnt = 0;
        bus.dn_resp  = 1'b0;
        bus.dn_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.dn_resp = 1'b0;
            n_cmp++;
            if (bus.dn_read && bus.dn_write) begin
                n_err++;
                $display("FAIL dn_overlap: dn_read=1 dn_write=1, required at most one");
            end
            if (!reset_n || !(bus.dn_read || bus.dn_write)) wcnt = 0;
            else if (!stall) begin
                if (wcnt < 1) wcnt++;
                else begin
                    wcnt = 0;
                    n_cmp++;
                    if (exp_dn.size() == 0) begin
                        n_err++;
                        $display("FAIL dn_unexpected: rd=%0b wr=%0b addr=%h, required no access", bus.dn_read, bus.dn_write, bus.dn_address);
                    end else begin
                        e = exp_dn.pop_front();
                        if ({bus.dn_write, bus.dn_read} !== {e.wr, !e.wr} || bus.dn_address !== e.a || (e.wr && bus.dn_wdata !== e.d)) begin
                            n_err++;
                            $display("FAIL dn_access: wr=%0b rd=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                                     bus.dn_write, bus.dn_read, bus.dn_address, bus.dn_wdata, e.wr, e.a, e.d);
                        end
                    end
                    if (bus.dn_write) mem[bus.dn_address] = bus.dn_wdata;
                    else bus.dn_rdata = mem.exists(bus.dn_address) ? mem[bus.dn_address] : mem_init(bus.dn_address);
                    bus.dn_resp = 1'b1;
                    n_dn_done++;
                end
            end
        end
    end

    task automatic l2_req(input bit wr, input logic [31:0] a, input logic [255:0] d, output int lat, output logic [255:0] rd);
        bus.up_address = a;
        bus.up_wdata   = d;
        bus.up_write   = wr;
        bus.up_read    = !wr;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.up_resp && lat < 300);
        rd = bus.up_rdata;
        @(posedge clk); #1;
        bus.up_read  = 1'b0;
        bus.up_write = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (exp_dn.size() != 0 || bus.count != 0 || bus.dn_read || bus.dn_write); i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({bus.up_resp, bus.dn_read, bus.dn_write, bus.count} !== '0 || bus.up_rdata !== '0 || bus.dn_address !== '0 || bus.dn_wdata !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: up_resp=%0b dn_read=%0b dn_write=%0b count=%0d dn_address=%h, required all zero",
                     bus.up_resp, bus.dn_read, bus.dn_write, bus.count, bus.dn_address);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.up_resp, bus.dn_read, bus.dn_write, bus.count} !== '0) begin
            n_err++;
            $display("FAIL reset_idle: up_resp=%0b dn_read=%0b dn_write=%0b count=%0d, required all zero",
                     bus.up_resp, bus.dn_read, bus.dn_write, bus.count);
        end
    endtask

    task automatic test_write_drain(input logic [31:0] a, input int n);
        int lat;
        logic [255:0] rd;
        exp_w(a, dp(n));
        l2_req(1'b1, a, dp(n), lat, rd);
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL write_latency: got %0d cycles, required 1", lat); end
        n_cmp++;
        if (bus.count !== 2'd1) begin n_err++; $display("FAIL write_count: got %0d, required 1", bus.count); end
        wait_drain();
        n_cmp++;
        if (bus.count !== 2'd0 || exp_dn.size() != 0) begin
            n_err++;
            $display("FAIL write_drained: count=%0d pending=%0d, required 0/0", bus.count, exp_dn.size());
        end
    endtask

    task automatic test_hit_coalesce();
        int lat;
        logic [255:0] rd;
        stall = 1'b1;
        exp_w(32'h100, dp(2));
        exp_w(32'h200, dp(4));
        l2_req(1'b1, 32'h100, dp(2), lat, rd);
        up_q.push_back(dp(2));
        l2_req(1'b0, 32'h100, '0, lat, rd);
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL read_hit_latency: got %0d cycles, required 1", lat); end
        n_cmp++;
        if (rd !== up_q.pop_front()) begin n_err++; $display("FAIL read_hit_data: got %h, required %h", rd, dp(2)); end
        l2_req(1'b1, 32'h200, dp(3), lat, rd);
        l2_req(1'b1, 32'h200, dp(4), lat, rd);
        n_cmp++;
        if (bus.count !== 2'd2) begin n_err++; $display("FAIL coalesce_count: got %0d, required 2", bus.count); end
        up_q.push_back(dp(4));
        l2_req(1'b0, 32'h200, '0, lat, rd);
        n_cmp++;
        if (rd !== up_q.pop_front() || lat !== 1) begin
            n_err++;
            $display("FAIL coalesce_read: got %h after %0d cycles, required %h after 1", rd, lat, dp(4));
        end
        stall = 1'b0;
        wait_drain();
        n_cmp++;
        if (bus.count !== 2'd0 || exp_dn.size() != 0) begin
            n_err++;
            $display("FAIL coalesce_drained: count=%0d pending=%0d, required 0/0", bus.count, exp_dn.size());
        end
    endtask

    task automatic test_head_lock();
        int lat;
        logic [255:0] rd;
        stall = 1'b1;
        exp_w(32'h100, dp(5));
        exp_w(32'h100, dp(6));
        l2_req(1'b1, 32'h100, dp(5), lat, rd);
        l2_req(1'b1, 32'h100, dp(6), lat, rd);
        n_cmp++;
        if (bus.count !== 2'd2) begin n_err++; $display("FAIL head_lock_count: got %0d, required 2", bus.count); end
        up_q.push_back(dp(6));
        l2_req(1'b0, 32'h100, '0, lat, rd);
        n_cmp++;
        if (rd !== up_q.pop_front()) begin n_err++; $display("FAIL head_lock_newest: got %h, required %h", rd, dp(6)); end
        stall = 1'b0;
        wait_drain();
        n_cmp++;
        if (bus.count !== 2'd0 || exp_dn.size() != 0) begin
            n_err++;
            $display("FAIL head_lock_drained: count=%0d pending=%0d, required 0/0", bus.count, exp_dn.size());
        end
    endtask

    task automatic test_full_stall();
        int lat;
        logic [255:0] rd;
        stall = 1'b1;
        exp_w(32'h100, dp(7));
        exp_w(32'h200, dp(8));
        exp_w(32'h300, dp(9));
        l2_req(1'b1, 32'h100, dp(7), lat, rd);
        l2_req(1'b1, 32'h200, dp(8), lat, rd);
        n_cmp++;
        if (bus.count !== 2'd2) begin n_err++; $display("FAIL full_count: got %0d, required 2", bus.count); end
        fork
            l2_req(1'b1, 32'h300, dp(9), lat, rd);
            begin repeat (6) @(posedge clk); stall = 1'b0; end
        join
        n_cmp++;
        if (lat <= 6) begin n_err++; $display("FAIL full_stall: resp after %0d cycles, required more than 6", lat); end
        wait_drain();
        n_cmp++;
        if (bus.count !== 2'd0 || exp_dn.size() != 0) begin
            n_err++;
            $display("FAIL full_drained: count=%0d pending=%0d, required 0/0", bus.count, exp_dn.size());
        end
    endtask

    task automatic test_read_priority();
        int lat;
        logic [255:0] rd;
        stall = 1'b1;
        exp_w(32'h100, dp(10));
        exp_r(32'h400);
        exp_w(32'h200, dp(11));
        l2_req(1'b1, 32'h100, dp(10), lat, rd);
        l2_req(1'b1, 32'h200, dp(11), lat, rd);
        up_q.push_back(mem_init(32'h400));
        fork
            l2_req(1'b0, 32'h40C, '0, lat, rd);
            begin repeat (4) @(posedge clk); stall = 1'b0; end
        join
        n_cmp++;
        if (rd !== up_q.pop_front()) begin n_err++; $display("FAIL miss_data: got %h, required %h", rd, mem_init(32'h400)); end
        wait_drain();
        n_cmp++;
        if (bus.count !== 2'd0 || exp_dn.size() != 0) begin
            n_err++;
            $display("FAIL priority_drained: count=%0d pending=%0d, required 0/0", bus.count, exp_dn.size());
        end
    endtask

    task automatic test_ordering();
        int lat;
        logic [255:0] rd;
        exp_w(32'h700, dp(12));
        l2_req(1'b1, 32'h700, dp(12), lat, rd);
        wait_drain();
        exp_r(32'h700);
        up_q.push_back(dp(12));
        l2_req(1'b0, 32'h700, '0, lat, rd);
        n_cmp++;
        if (rd !== up_q.pop_front() || lat <= 1) begin
            n_err++;
            $display("FAIL order_after_drain: got %h after %0d cycles, required %h from memory", rd, lat, dp(12));
        end
        n_cmp++;
        if (exp_dn.size() != 0) begin n_err++; $display("FAIL order_pending: got %0d accesses left, required 0", exp_dn.size()); end
    endtask

    task automatic test_reset_mid_read();
        stall = 1'b1;
        bus.up_address = 32'h600;
        bus.up_read    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.dn_read !== 1'b1 || bus.dn_address !== 32'h600) begin
            n_err++;
            $display("FAIL miss_issued: dn_read=%0b addr=%h, required 1/00000600", bus.dn_read, bus.dn_address);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.dn_read, bus.dn_write, bus.up_resp, bus.count} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_read: dn_read=%0b dn_write=%0b up_resp=%0b count=%0d, required all zero",
                     bus.dn_read, bus.dn_write, bus.up_resp, bus.count);
        end
        bus.up_read = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        stall   = 1'b0;
        @(posedge clk); #1;
        test_write_drain(32'h500, 13);
    endtask

    initial begin
        bus.up_address = '0;
        bus.up_read    = 1'b0;
        bus.up_write   = 1'b0;
        bus.up_wdata   = '0;
        test_reset();
        test_write_drain(32'h100, 1);
        test_hit_coalesce();
        test_head_lock();
        test_full_stall();
        test_read_priority();
        test_ordering();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
